// File: rtl/pipe_skid_latch.sv
// Elastic pipeline stage with 2-entry skid buffer, flush and stall counter; 1-cycle latency.
// in_ready decodes only the state register, so back-pressure takes effect one cycle later with no combinational path.
module pipe_skid_latch #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                in_fire;
  logic                out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    stall_cnt_d = stall_cnt_q;

    // Counted from the pre-flush view of the handshake.
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Control depends only on valid/ready/flush so X payloads never reach the state.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/pipe_skid_latch.md
Name: pipe_skid_latch

Overview:
- Parametrised, elastic successor to the fixed ID/EX enable-latch: one pipeline stage between any two core stages (IF/ID, ID/EX, EX/MEM).
- Uses a valid/ready handshake with a 2-entry skid buffer, so there is no combinational path between the input and output handshake signals and throughput is full.
- Adds flush (bubble insertion) and masks control bits to zero on bubbles.
- Provides a saturating back-pressure counter for performance monitoring.

Parameters:
- DATA_W, 128: payload width (operand values, PC, immediates, register indices); never cleared on bubbles.
- CTRL_W, 16: control-bit width (reg_we, mem_we, mem_re, ...); forced to 0 whenever the slot is invalid.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  kill all held entries this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  control bits of the head entry, 0 when out_valid=0.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: a main register (drives the out_* ports) and a skid register. State is EMPTY (occ 0), ONE (occ 1) or FULL (occ 2); occupancy encodes the state directly.
- in_ready = (state != FULL). It is a decode of the state register only, with no dependence on out_ready or in_valid.
- Handshake fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid = (state != EMPTY).
- Reset (rst=0 at clk edge), highest priority:
  - state EMPTY; out_valid=0; in_ready=1 after the edge.
  - main and skid data/ctrl = 0; stall_cnt=0; occupancy=0.
- Flush (rst=1, flush=1), next priority:
  - state EMPTY; out_valid=0; out_ctrl=0.
  - A same-cycle in_fire is discarded; out_fire in that cycle still counts as accepted downstream.
  - Data registers keep their stale values. stall_cnt is unaffected.
- Transitions (rst=1, flush=0):
  - EMPTY: in_fire -> main<=in, go to ONE. Otherwise stay EMPTY.
  - ONE, in_fire & out_fire: main<=in, stay ONE.
  - ONE, in_fire only: skid<=in, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - ONE, neither: hold.
  - FULL: in_fire impossible. out_fire -> main<=skid, go to ONE; otherwise hold.
- Latency: 1 cycle from in_fire (into EMPTY) to out_valid=1.
- Throughput: 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_ctrl are held constant.
- out_ctrl is the main ctrl AND-ed with out_valid, so bubbles never assert write enables.
- stall_cnt:
  - +1 on each cycle with out_valid & !out_ready (sampled before a flush takes effect).
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- An X on in_data must not propagate into state; only in_valid, out_ready and flush affect control.

Test Plan:
- Reset then streaming: rst=0 for 2 cycles, then in_valid=1 with in_data=0..9 and out_ready=1.
  -> out_valid rises 1 cycle after the first fire; out_data=0..9 on consecutive cycles; occupancy stays 1; in_ready stays 1; stall_cnt=0.
- Back-pressure fill: out_ready=0 while pushing A, B, C.
  -> A and B accepted; occupancy=2; in_ready=0; C held upstream; out_data=A stable; stall_cnt increments by 1 each stalled cycle.
  -> Release out_ready: outputs A, B, C in order.
- Flush while FULL with in_valid=1 and in_data=D in the same cycle.
  -> Next cycle: occupancy=0; out_valid=0; out_ctrl=0; D never appears on the output.
- Bubble masking: push an entry with in_ctrl=16'hFFFF, pop it, then idle.
  -> During the idle cycle out_ctrl=0 while out_data retains the last payload.
- Counter saturation with CNT_W=4: out_valid=1 and out_ready=0 for 20 cycles.
  -> stall_cnt reaches 15 and stays at 15; a reset mid-stall returns it to 0 and occupancy to 0.
- Reset mid-transfer: assert rst=0 in the same cycle as in_fire and out_fire while in state ONE.
  -> Next cycle: all outputs are zero and in_ready=1; the accepted entry is lost.
